// File: rtl/pc_fetch_stage_if.sv
// Fetch-stage bundle: PC adder result, redirect requests and hazard stall
// in; current PC and IF/ID latch contents out.
interface pc_fetch_stage_if;
    logic [31:0] PCAddResult;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic        Jump;
    logic [31:0] JumpTarget;
    logic        Stall;
    logic [31:0] PCResult;
    logic [31:0] IFID_PCPlus4;
    logic        IFID_Valid;
    logic        RedirectPending;
    logic        MisalignErr;

    modport master (
        output PCAddResult, BranchTaken, BranchTarget, Jump, JumpTarget, Stall,
        input  PCResult, IFID_PCPlus4, IFID_Valid, RedirectPending, MisalignErr
    );

    modport slave (
        input  PCAddResult, BranchTaken, BranchTarget, Jump, JumpTarget, Stall,
        output PCResult, IFID_PCPlus4, IFID_Valid, RedirectPending, MisalignErr
    );
endinterface

// File: rtl/pc_fetch_stage.sv
// PC register and IF/ID boundary with a one-entry parked-redirect buffer.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   RUN     | normal fetch; redirects applied, or parked if stalled
//   PENDING | a redirect is parked; wait for stall release, ignore new ones
module pc_fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              Clk,
    input  logic              Reset,
    pc_fetch_stage_if.slave   bus
);
    typedef enum logic {RUN = 1'b0, PENDING = 1'b1} state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] ifid_pc4;
    logic        ifid_valid;
    logic [31:0] pend_target;
    logic        misalign_err;

    logic        redirect;
    logic [31:0] tsel;
    logic [31:0] tsel_aligned;

    // Branch wins over jump because the branch is the older instruction.
    assign redirect     = bus.BranchTaken | bus.Jump;
    assign tsel         = bus.BranchTaken ? bus.BranchTarget : bus.JumpTarget;
    assign tsel_aligned = {tsel[31:2], 2'b00};

    // PC, IF/ID latch, parked target and sticky misalignment flag.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state        <= RUN;
            pc           <= RESET_PC;
            ifid_pc4     <= 32'h0;
            ifid_valid   <= 1'b0;
            pend_target  <= 32'h0;
            misalign_err <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (redirect) begin
                        if (tsel[1:0] != 2'b00)
                            misalign_err <= 1'b1;
                        ifid_valid <= 1'b0;
                        if (!bus.Stall) begin
                            pc       <= tsel_aligned;
                            ifid_pc4 <= bus.PCAddResult;
                        end else begin
                            pend_target <= tsel_aligned;
                            state       <= PENDING;
                        end
                    end else if (!bus.Stall) begin
                        pc         <= bus.PCAddResult;
                        ifid_pc4   <= bus.PCAddResult;
                        ifid_valid <= 1'b1;
                    end
                end
                PENDING: begin
                    // Redirects seen here are wrong-path and dropped.
                    if (!bus.Stall) begin
                        pc         <= pend_target;
                        ifid_valid <= 1'b0;
                        state      <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    assign bus.PCResult        = pc;
    assign bus.IFID_PCPlus4    = ifid_pc4;
    assign bus.IFID_Valid      = ifid_valid;
    assign bus.RedirectPending = (state == PENDING);
    assign bus.MisalignErr     = misalign_err;
endmodule

// File: doc/pc_fetch_stage.md
# pc_fetch_stage

Program-counter register and IF/ID boundary for the single-issue MIPS pipeline. Holds the current PC, which drives the PC+4 adder and instruction memory. Each cycle it selects the next PC from the adder's PC+4 result, a branch target, or a jump target, subject to hazard stalls. It also captures PC+4 into the IF/ID latch with a valid bit. A redirect that arrives while the front end is stalled is parked in a one-entry pending register and applied when the stall releases.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset. Must be word aligned.

Ports:
- Clk  in  1: pipeline clock. All state updates on the rising edge.
- Reset  in  1: asynchronous, active-high. Clears all state immediately.
- PCAddResult  in  32: current PC + 4, from the PC adder.
- BranchTaken  in  1: a resolved branch redirects fetch (EX stage).
- BranchTarget  in  32: branch target address.
- Jump  in  1: a jump redirects fetch (ID stage).
- JumpTarget  in  32: jump target address.
- Stall  in  1: hazard unit freeze. PC and IF/ID hold.
- PCResult  out  32: current PC. Goes to the PC adder and instruction memory.
- IFID_PCPlus4  out  32: PC+4 of the instruction held in IF/ID.
- IFID_Valid  out  1: 1 = IF/ID holds a live instruction; 0 = bubble.
- RedirectPending  out  1: 1 while a parked redirect awaits stall release.
- MisalignErr  out  1: sticky flag. Set when an applied or parked target has bits [1:0] ≠ 0.

## Operation
- Redirect selection: BranchTaken has priority over Jump, because the branch is the older instruction. The selected target is Tsel. The PC always loads {Tsel[31:2], 2'b00}.
- State RUN (reset state), evaluated each rising edge:
  - Redirect and !Stall: PCResult ← aligned Tsel; IFID_Valid ← 0; IFID_PCPlus4 ← PCAddResult. The squashed value is don't-care but deterministic.
  - Redirect and Stall: PendTarget ← aligned Tsel; go to PENDING; PCResult holds; IFID_Valid ← 0; IFID_PCPlus4 holds.
  - No redirect and Stall: PCResult, IFID_PCPlus4 and IFID_Valid all hold.
  - No redirect and !Stall: PCResult ← PCAddResult; IFID_PCPlus4 ← PCAddResult; IFID_Valid ← 1.
- State PENDING:
  - Stall high: everything holds and IFID_Valid stays 0. Any new BranchTaken or Jump is ignored; it is wrong-path.
  - Stall low: PCResult ← PendTarget; IFID_Valid ← 0; go to RUN. A redirect in this same cycle is ignored.
- RedirectPending = (state == PENDING). It is a registered output.
- MisalignErr:
  - Set on any edge where a redirect is accepted (applied or parked) and Tsel[1:0] ≠ 0.
  - Once set, cleared only by Reset.
  - A redirect ignored in PENDING never sets it.
- Arithmetic: no addition inside this block. PC+4 wrap from 32'hFFFF_FFFC to 32'h0 is passed through unchanged.

## Timing
- Reset values: PCResult = RESET_PC; IFID_PCPlus4 = 0; IFID_Valid = 0; RedirectPending = 0; MisalignErr = 0; state = RUN; PendTarget = 0.
- Reset asserted mid-operation, including in PENDING: all state returns to reset values immediately, independent of Clk. The parked target is discarded.
- First edge after Reset deasserts with Stall = 0: PCResult ← PCAddResult (RESET_PC + 4); IFID_Valid ← 1.
- Redirect latency: control sampled at edge n → PCResult = target immediately after edge n. The first target-path IF/ID entry becomes valid after edge n+1.
- Parked redirect: the target appears after the first edge at which Stall = 0 is sampled.
- All outputs are registered. No combinational path from any input to any output.

## Test plan
- Reset and sequential fetch:
  - Stimulus: RESET_PC = 0x0; hold Reset 2 cycles; release; keep PCAddResult = PCResult + 4.
  - Required: PCResult 0x0 → 0x4 → 0x8 → 0xC; IFID_PCPlus4 lags by one edge; IFID_Valid = 1 from the first edge.
- Simultaneous redirects:
  - Stimulus: at PC 0x10, BranchTaken = 1, BranchTarget = 0x100, Jump = 1, JumpTarget = 0x200, both for one edge.
  - Required: PCResult = 0x100; IFID_Valid = 0 for one cycle; then PC 0x104 with valid = 1.
- Stall hold:
  - Stimulus: Stall = 1 for 3 edges at PC 0x20.
  - Required: PCResult stays 0x20; IFID_PCPlus4 and IFID_Valid unchanged; on release PCResult = 0x24.
- Parked redirect:
  - Stimulus: Stall = 1; Jump = 1, JumpTarget = 0x400 for one edge; a second Jump to 0x800 two edges later; Stall drops after 4 edges.
  - Required: RedirectPending = 1 throughout the stall; IFID_Valid = 0; after release PCResult = 0x400 (not 0x800); RedirectPending = 0.
- Misalignment:
  - Stimulus: BranchTaken with BranchTarget = 0x103.
  - Required: PCResult = 0x100; MisalignErr = 1 and stays 1 across later redirects until Reset.
- Async reset in PENDING:
  - Stimulus: assert Reset mid-cycle while RedirectPending = 1.
  - Required: immediately PCResult = RESET_PC, RedirectPending = 0, IFID_Valid = 0; after release, fetch resumes from RESET_PC + 4.
